fft_bin_reader: RTL and testbench
=================================

Name: fft_bin_reader

Overview:
Reader on the vga side of the FFT processor result memory. On each completed transform it sweeps all 2**ADDR_WIDTH bins through the vga_addr/vga_data_r/vga_data_i port and computes an approximate magnitude per bin. It stores the magnitudes in a local frame buffer, which the display logic reads independently, and tracks the frame's peak bin. It sits between FFT_processor and the bar-graph renderer.

Parameters:
ADDR_WIDTH, 5, log2 of FFT length N; width of vga_addr, disp_addr and bin indices
DATA_WIDTH, 18, width of the signed two's-complement real/imag bin values
MAG_WIDTH, DATA_WIDTH+1, width of the unsigned magnitude; fixed relation, not overridden

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-low reset
fft_done  in  1  level from FFT_processor, high while results are valid
vga_addr  out  ADDR_WIDTH  bin address to FFT_processor result memory
vga_data_r  in  DATA_WIDTH  signed real part, valid 1 cycle after vga_addr
vga_data_i  in  DATA_WIDTH  signed imag part, valid 1 cycle after vga_addr
busy  out  1  high from scan start until frame_done
bin_valid  out  1  one-cycle strobe per computed bin
bin_index  out  ADDR_WIDTH  index of the bin on bin_valid
bin_mag  out  MAG_WIDTH  magnitude of the bin on bin_valid
frame_done  out  1  one-cycle pulse after the last bin is written
peak_index  out  ADDR_WIDTH  index of the largest bin of the last completed frame
peak_mag  out  MAG_WIDTH  magnitude of that bin
disp_addr  in  ADDR_WIDTH  display read address
disp_mag  out  MAG_WIDTH  buffer[disp_addr], registered, 1-cycle latency

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all outputs 0, including vga_addr, disp_mag, peak_index and peak_mag. The frame buffer contents are not cleared, so it can map to block RAM.
- Start detection: fft_done is registered. A scan starts on a sampled rising edge (prev 0, now 1). A level held high from reset does not start a scan, since prev resets to 1.
- FSM states: IDLE, READ, DRAIN, FIN.
  - IDLE -> READ on the start edge; busy goes high in the same cycle vga_addr=0 is driven.
  - READ: vga_addr increments by 1 per cycle from 0 to LAST, then -> DRAIN. LAST is N-1 without the optional feature.
  - DRAIN: waits for the pipeline to empty (2 cycles), then -> FIN.
  - FIN: frame_done=1 for one cycle, peak outputs updated, busy=0; -> IDLE.
- Pipeline:
  - Address k is driven in cycle t; data arrives in t+1.
  - Stage 1 registers |r| and |i| at the end of t+1.
  - Stage 2 registers mag = max + (min >> 1) at the end of t+2.
  - bin_valid=1, bin_index=k and bin_mag=mag are visible in cycle t+2, and the buffer is written with that value at the same edge.
  - Throughput is 1 bin per cycle.
- Arithmetic: abs is computed at DATA_WIDTH+1 bits so that -2**(DATA_WIDTH-1) maps to +2**(DATA_WIDTH-1). The sum is computed in MAG_WIDTH+1 bits and saturates to 2**MAG_WIDTH-1; the maximum true value is 1.5*2**(DATA_WIDTH-1), so saturation never actually triggers.
- Peak tracking: a running max is reset at scan start. It is updated when mag > running max (strict), so ties keep the lowest index. It is copied to peak_index/peak_mag in FIN. Between frames the peak outputs hold their values.
- Display port: disp_mag <= buffer[disp_addr] every cycle, regardless of state. On a same-cycle write and read of one address, the read returns the old value (read-before-write).
- A new fft_done rising edge while busy is ignored and is not queued.
- fft_done falling during a scan is ignored; the scan completes.
- Reset mid-scan aborts immediately. No frame_done is issued and the peak outputs return to 0. The buffer holds a partial frame until the next scan.
- bin_valid is 0 outside the 2-cycle-lagged READ window. bin_index and bin_mag hold their last values when bin_valid is 0.

Optional Feature:
HALF_SPECTRUM_EN
- Defined: LAST = N/2-1. Only bins 0..N/2-1 are read, since the input is real and the spectrum is symmetric. Buffer entries N/2..N-1 are never written. A scan produces N/2 bin_valid strobes.
- Undefined: all N bins are read, stored and counted for the peak.

Test Plan:
- Reset with fft_done held at 1, then release -> no scan; busy=0 and all outputs 0. Drop fft_done to 0 and raise it again -> scan starts, vga_addr=0 in the cycle after the edge is sampled.
- Bin 3 returns r=3, i=-4 -> bin_valid with bin_index=3 and bin_mag=5 (4+1), exactly 2 cycles after vga_addr=3.
- Bin 7 returns r=-131072, i=0 (DATA_WIDTH=18) -> bin_mag=131072, no overflow or sign error.
- Full 32-bin scan with bins 9 and 20 both mag 600 and all others smaller -> 32 consecutive bin_valid strobes, then frame_done one cycle after the last; peak_index=9, peak_mag=600; reading disp_addr=20 returns 600 the next cycle.
- Second fft_done rise mid-scan -> no restart, exactly one frame_done. Assert rst low at bin 10 -> all outputs 0 immediately, no frame_done, and a later fft_done edge starts a clean scan.
- With HALF_SPECTRUM_EN defined -> 16 strobes with indices 0..15, vga_addr never exceeds 15, and the peak is taken over bins 0..15 only.

Source files
------------

// File: rtl/fft_bin_reader.sv
// Sweeps the FFT result memory after each transform, stores an approximate magnitude
// per bin in a display buffer and tracks the frame peak. Option macro: HALF_SPECTRUM_EN.
module fft_bin_reader #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 18,
  localparam int MAG_WIDTH = DATA_WIDTH + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fft_done,
  output logic [ADDR_WIDTH-1:0]        vga_addr,
  input  logic signed [DATA_WIDTH-1:0] vga_data_r,
  input  logic signed [DATA_WIDTH-1:0] vga_data_i,
  output logic                         busy,
  output logic                         bin_valid,
  output logic [ADDR_WIDTH-1:0]        bin_index,
  output logic [MAG_WIDTH-1:0]         bin_mag,
  output logic                         frame_done,
  output logic [ADDR_WIDTH-1:0]        peak_index,
  output logic [MAG_WIDTH-1:0]         peak_mag,
  input  logic [ADDR_WIDTH-1:0]        disp_addr,
  output logic [MAG_WIDTH-1:0]         disp_mag
);

`ifdef HALF_SPECTRUM_EN
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'((1 << (ADDR_WIDTH - 1)) - 1);
`else
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'((1 << ADDR_WIDTH) - 1);
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2, FIN = 2'd3} state_t;

  // One extra bit so the most negative input maps to a positive magnitude.
  function automatic logic [MAG_WIDTH-1:0] abs_f(input logic signed [DATA_WIDTH-1:0] v);
    logic signed [MAG_WIDTH-1:0] ext;
    ext = {v[DATA_WIDTH-1], v};
    if (ext[MAG_WIDTH-1]) begin
      abs_f = MAG_WIDTH'(-ext);
    end else begin
      abs_f = MAG_WIDTH'(ext);
    end
  endfunction

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   vga_addr_q, vga_addr_d;
  logic                    drain_q, drain_d;
  logic                    fd_q, fd_prev_q, start_s;
  logic                    busy_q, frame_done_q;
  logic                    rd_valid_q;
  logic [ADDR_WIDTH-1:0]   rd_idx_q;
  logic                    bin_valid_q;
  logic [ADDR_WIDTH-1:0]   idx1_q;
  logic [MAG_WIDTH-1:0]    abs_r_q, abs_i_q;
  logic [MAG_WIDTH-1:0]    mx_s, mn_s, mag_s;
  logic [MAG_WIDTH:0]      sum_s;
  logic [MAG_WIDTH-1:0]    run_mag_q, run_mag_d;
  logic [ADDR_WIDTH-1:0]   run_idx_q, run_idx_d;
  logic [ADDR_WIDTH-1:0]   peak_idx_q;
  logic [MAG_WIDTH-1:0]    peak_mag_q;
  logic [MAG_WIDTH-1:0]    disp_mag_q;
  logic [MAG_WIDTH-1:0]    fbuf_q [2**ADDR_WIDTH];

  assign start_s = fd_q & ~fd_prev_q;

  // Scan sequencing: address sweep, pipeline drain, then a single finish cycle.
  always_comb begin
    state_d    = state_q;
    vga_addr_d = '0;
    drain_d    = drain_q;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          state_d = READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (vga_addr_q == LAST) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end else begin
          vga_addr_d = vga_addr_q + ADDR_WIDTH'(1);
        end
      end
      DRAIN: begin
        if (drain_q) begin
          state_d = FIN;
        end else begin
          drain_d = 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Magnitude approximation max + min/2, saturated to the output width.
  always_comb begin
    if (abs_r_q >= abs_i_q) begin
      mx_s = abs_r_q;
      mn_s = abs_i_q;
    end else begin
      mx_s = abs_i_q;
      mn_s = abs_r_q;
    end
    sum_s = {1'b0, mx_s} + {2'b00, mn_s[MAG_WIDTH-1:1]};
    if (sum_s[MAG_WIDTH]) begin
      mag_s = '1;
    end else begin
      mag_s = sum_s[MAG_WIDTH-1:0];
    end
  end

  // Running peak; strict compare keeps the lowest index on ties.
  always_comb begin
    if (bin_valid_q && (mag_s > run_mag_q)) begin
      run_mag_d = mag_s;
      run_idx_d = idx1_q;
    end else begin
      run_mag_d = run_mag_q;
      run_idx_d = run_idx_q;
    end
  end

  // Control, pipeline and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fd_q         <= 1'b1;
      fd_prev_q    <= 1'b1;
      state_q      <= IDLE;
      vga_addr_q   <= '0;
      drain_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_idx_q     <= '0;
      bin_valid_q  <= 1'b0;
      idx1_q       <= '0;
      abs_r_q      <= '0;
      abs_i_q      <= '0;
      run_mag_q    <= '0;
      run_idx_q    <= '0;
      peak_idx_q   <= '0;
      peak_mag_q   <= '0;
      disp_mag_q   <= '0;
    end else begin
      fd_q         <= fft_done;
      fd_prev_q    <= fd_q;
      state_q      <= state_d;
      vga_addr_q   <= vga_addr_d;
      drain_q      <= drain_d;
      busy_q       <= (state_d == READ) || (state_d == DRAIN);
      frame_done_q <= (state_d == FIN);
      rd_valid_q   <= (state_q == READ);
      rd_idx_q     <= vga_addr_q;
      bin_valid_q  <= rd_valid_q;
      if (rd_valid_q) begin
        abs_r_q <= abs_f(vga_data_r);
        abs_i_q <= abs_f(vga_data_i);
        idx1_q  <= rd_idx_q;
      end
      if ((state_q == IDLE) && start_s) begin
        run_mag_q <= '0;
        run_idx_q <= '0;
      end else begin
        run_mag_q <= run_mag_d;
        run_idx_q <= run_idx_d;
      end
      if (state_d == FIN) begin
        peak_idx_q <= run_idx_d;
        peak_mag_q <= run_mag_d;
      end
      disp_mag_q <= fbuf_q[disp_addr];
    end
  end

  // Frame buffer without reset so it can map to block RAM.
  always_ff @(posedge clk) begin
    if (bin_valid_q) begin
      fbuf_q[idx1_q] <= mag_s;
    end
  end

  assign vga_addr   = vga_addr_q;
  assign busy       = busy_q;
  assign bin_valid  = bin_valid_q;
  assign bin_index  = idx1_q;
  assign bin_mag    = mag_s;
  assign frame_done = frame_done_q;
  assign peak_index = peak_idx_q;
  assign peak_mag   = peak_mag_q;
  assign disp_mag   = disp_mag_q;

endmodule

// File: tb/tb_fft_bin_reader.sv
// Directed-sequence bench for fft_bin_reader with randomized bin data and a
// behavioural magnitude/peak model.
module tb_fft_bin_reader;
  localparam int AW = 5;
  localparam int DW = 18;
  localparam int MW = DW + 1;
  localparam int N  = 32;
`ifdef HALF_SPECTRUM_EN
  localparam int NB = N / 2;
`else
  localparam int NB = N;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 fft_done;
  logic [AW-1:0]        vga_addr;
  logic signed [DW-1:0] vga_data_r, vga_data_i;
  logic                 busy, bin_valid, frame_done;
  logic [AW-1:0]        bin_index, peak_index, disp_addr;
  logic [MW-1:0]        bin_mag, peak_mag, disp_mag;

  fft_bin_reader dut (
    .clk(clk), .rst(rst), .fft_done(fft_done), .vga_addr(vga_addr),
    .vga_data_r(vga_data_r), .vga_data_i(vga_data_i), .busy(busy),
    .bin_valid(bin_valid), .bin_index(bin_index), .bin_mag(bin_mag),
    .frame_done(frame_done), .peak_index(peak_index), .peak_mag(peak_mag),
    .disp_addr(disp_addr), .disp_mag(disp_mag)
  );

  always #5 clk = ~clk;

  int mem_r [N];
  int mem_i [N];
  int model_buf [N];
  int cyc = 0;
  int passes = 0, fails = 0, total = 0;

  int q_idx [$];
  int q_mag [$];
  int q_cyc [$];
  int addr_cyc [N];
  bit addr_seen [N];
  int fd_cnt = 0, fd_cyc = 0, max_addr = 0;

  // result memory: one-cycle read latency
  always @(posedge clk) begin
    cyc <= cyc + 1;
    vga_data_r <= DW'(mem_r[vga_addr]);
    vga_data_i <= DW'(mem_i[vga_addr]);
  end

  always @(negedge clk) begin
    if (busy) begin
      if (!addr_seen[vga_addr]) begin
        addr_seen[vga_addr] = 1'b1;
        addr_cyc[vga_addr] = cyc;
      end
      if (int'(vga_addr) > max_addr) max_addr = int'(vga_addr);
    end
    if (bin_valid) begin
      q_idx.push_back(int'(bin_index));
      q_mag.push_back(int'(bin_mag));
      q_cyc.push_back(cyc);
    end
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int mag_m(input int r, input int i);
    int ar, ai, mx, mn;
    ar = (r < 0) ? -r : r;
    ai = (i < 0) ? -i : i;
    mx = (ar > ai) ? ar : ai;
    mn = (ar > ai) ? ai : ar;
    return mx + mn / 2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fill_small(input int lim);
    for (int k = 0; k < N; k++) begin
      mem_r[k] = int'($urandom_range(2 * lim)) - lim;
      mem_i[k] = int'($urandom_range(2 * lim)) - lim;
    end
  endtask

  task automatic fill_full();
    logic signed [DW-1:0] t;
    for (int k = 0; k < N; k++) begin
      t = DW'($urandom);
      mem_r[k] = t;
      t = DW'($urandom);
      mem_i[k] = t;
    end
  endtask

  task automatic start_scan(input bit glitch);
    q_idx.delete(); q_mag.delete(); q_cyc.delete();
    fd_cnt = 0; fd_cyc = 0; max_addr = 0;
    for (int k = 0; k < N; k++) addr_seen[k] = 1'b0;
    fft_done = 1'b0;
    tick(); tick();
    fft_done = 1'b1;
    if (glitch) begin
      repeat (8) tick();
      fft_done = 1'b0;
      tick(); tick();
      fft_done = 1'b1;
    end
  endtask

  task automatic wait_frame(input string tag);
    int n = 0;
    while (fd_cnt == 0 && n < 200) begin
      tick();
      n++;
    end
    check({tag, " frame_done_seen"}, fd_cnt != 0, 1);
    repeat (4) tick();
  endtask

  task automatic verify_scan(input string tag);
    int pk_i, pk_m, m, cnt, last;
    pk_i = 0; pk_m = -1;
    for (int k = 0; k < NB; k++) begin
      m = mag_m(mem_r[k], mem_i[k]);
      model_buf[k] = m;
      if (m > pk_m) begin pk_m = m; pk_i = k; end
    end
    cnt = q_idx.size();
    check({tag, " strobe_count"}, cnt, NB);
    for (int j = 0; j < cnt && j < NB; j++) begin
      check($sformatf("%s idx[%0d]", tag, j), q_idx[j], j);
      check($sformatf("%s mag[%0d]", tag, j), q_mag[j], model_buf[j]);
      check($sformatf("%s latency[%0d]", tag, j), q_cyc[j] - addr_cyc[j], 2);
      check($sformatf("%s back_to_back[%0d]", tag, j), q_cyc[j] - q_cyc[0], j);
    end
    last = (cnt > 0) ? q_cyc[cnt-1] : -100;
    check({tag, " frame_done_count"}, fd_cnt, 1);
    check({tag, " frame_done_timing"}, fd_cyc, last + 1);
    check({tag, " max_vga_addr"}, max_addr, NB - 1);
    check({tag, " peak_index"}, peak_index, pk_i);
    check({tag, " peak_mag"}, peak_mag, pk_m);
    check({tag, " busy_after"}, busy, 0);
  endtask

  task automatic disp_chk(input int a);
    disp_addr = AW'(a);
    tick();
    check($sformatf("disp_mag[%0d]", a), disp_mag, model_buf[a]);
  endtask

  initial begin
    int n;
    rst = 1'b0; fft_done = 1'b1; disp_addr = '0;
    for (int k = 0; k < N; k++) begin mem_r[k] = 0; mem_i[k] = 0; model_buf[k] = 0; end
    repeat (3) tick();
    check("rst busy", busy, 0);
    check("rst vga_addr", vga_addr, 0);
    check("rst bin_valid", bin_valid, 0);
    check("rst bin_mag", bin_mag, 0);
    check("rst frame_done", frame_done, 0);
    check("rst peak_index", peak_index, 0);
    check("rst peak_mag", peak_mag, 0);
    check("rst disp_mag", disp_mag, 0);
    rst = 1'b1;
    fd_cnt = 0;
    repeat (8) tick();
    check("held_level busy", busy, 0);
    check("held_level vga_addr", vga_addr, 0);
    check("held_level no_strobes", q_idx.size(), 0);
    check("held_level no_frame", fd_cnt, 0);

    // scan A: bin 3 = 3-4j, bin 7 = most negative real
    fill_small(300);
    mem_r[3] = 3; mem_i[3] = -4;
    mem_r[7] = -131072; mem_i[7] = 0;
    start_scan(1'b0);
    wait_frame("A");
    verify_scan("A");
    check("A bin3_mag", (q_mag.size() > 3) ? q_mag[3] : -1, 5);
    check("A bin7_mag", (q_mag.size() > 7) ? q_mag[7] : -1, 131072);

    // scan B: tied peaks at 9 and 20, with a second fft_done rise mid-scan
    fill_small(300);
    mem_r[9] = 600; mem_i[9] = 0;
    mem_r[20] = 0; mem_i[20] = -600;
    start_scan(1'b1);
    wait_frame("B");
    verify_scan("B");
    check("B tie peak_index", peak_index, 9);
    check("B tie peak_mag", peak_mag, 600);
    disp_chk(NB > 20 ? 20 : 9);
    disp_chk(3);
    repeat (10) tick();
    check("B no_requeue frames", fd_cnt, 1);
    check("B no_requeue busy", busy, 0);

    // scan C: aborted by reset at bin 10
    fill_full();
    start_scan(1'b0);
    n = 0;
    while (!(bin_valid && bin_index == AW'(10)) && n < 100) begin
      tick();
      n++;
    end
    check("C reached_bin10", bin_valid && bin_index == AW'(10), 1);
    rst = 1'b0;
    #1;
    check("C abort busy", busy, 0);
    check("C abort vga_addr", vga_addr, 0);
    check("C abort bin_valid", bin_valid, 0);
    check("C abort bin_index", bin_index, 0);
    check("C abort bin_mag", bin_mag, 0);
    check("C abort peak_index", peak_index, 0);
    check("C abort peak_mag", peak_mag, 0);
    check("C abort disp_mag", disp_mag, 0);
    tick(); tick();
    rst = 1'b1;
    repeat (40) tick();
    check("C abort no_frame", fd_cnt, 0);
    check("C abort idle", busy, 0);
    check("C abort peak_hold", peak_mag, 0);

    // scan D: clean full-range scan after the abort
    fill_full();
    mem_r[0] = -131072; mem_i[0] = -131072;
    start_scan(1'b0);
    wait_frame("D");
    verify_scan("D");
    disp_chk(0);
    disp_chk(5);
    disp_chk(NB - 1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
